// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver: assembles WIDTH-bit MSB-first words framed by SOF
// and hands them to a consumer through a valid/ready holding register.
//
// state | meaning
// IDLE  | no frame in progress, waiting for SOF
// SHIFT | accumulating a word, cnt bits collected so far
module sipo_deserializer #(
    parameter int WIDTH       = 4,
    parameter bit REQUIRE_SOF = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SIN,
    input  logic             SIN_EN,
    input  logic             SOF,
    output logic [WIDTH-1:0] DOUT,
    output logic             DOUT_VALID,
    input  logic             DOUT_READY,
    output logic             FRAME_ERR,
    output logic             OVERRUN,
    input  logic             CLR_OVR,
    output logic             BUSY
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n, word;
    logic [CW-1:0]    cnt, cnt_n;
    logic             word_done, frame_err_n, load_out, drop;

    always_comb begin
        state_n     = state;
        sreg_n      = sreg;
        cnt_n       = cnt;
        word_done   = 1'b0;
        frame_err_n = 1'b0;
        word        = {sreg[WIDTH-2:0], SIN};
        if (SIN_EN) begin
            if (SOF) begin
                // SOF always restarts; it only counts as an error if bits were pending
                frame_err_n = (state == SHIFT) && (cnt != '0);
                state_n     = SHIFT;
                sreg_n      = {{(WIDTH-1){1'b0}}, SIN};
                cnt_n       = CW'(1);
            end else if (state == SHIFT) begin
                if (cnt == LAST) begin
                    word_done = 1'b1;
                    sreg_n    = '0;
                    cnt_n     = '0;
                    state_n   = REQUIRE_SOF ? IDLE : SHIFT;
                end else begin
                    sreg_n = word;
                    cnt_n  = cnt + 1'b1;
                end
            end
        end
    end

    // A finished word may replace one that is being drained in the same cycle
    assign load_out = word_done && (!DOUT_VALID || DOUT_READY);
    assign drop     = word_done && DOUT_VALID && !DOUT_READY;
    assign BUSY     = (state == SHIFT) && (cnt != '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            sreg  <= sreg_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DOUT       <= '0;
            DOUT_VALID <= 1'b0;
            FRAME_ERR  <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            FRAME_ERR <= frame_err_n;
            if (load_out) begin
                DOUT       <= word;
                DOUT_VALID <= 1'b1;
            end else if (DOUT_VALID && DOUT_READY) begin
                DOUT_VALID <= 1'b0;
            end
            if (drop)
                OVERRUN <= 1'b1;
            else if (CLR_OVR)
                OVERRUN <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: two instances (REQUIRE_SOF=0 and 1) share stimulus and
// are compared every cycle against a bit-counting reference model.
module tb_sipo_deserializer;
    localparam int W = 4;

    logic CLK, RST, SIN, SIN_EN, SOF, DOUT_READY, CLR_OVR;
    logic [W-1:0] dout0, dout1;
    logic valid0, valid1, ferr0, ferr1, ovr0, ovr1, busy0, busy1;

    int errors = 0;
    int checks = 0;

    // index 0: REQUIRE_SOF=0, index 1: REQUIRE_SOF=1
    bit      act [2];
    int      nb  [2];
    longint  acc [2];
    logic [W-1:0] md [2];
    logic    mv [2], mf [2], mo [2];

    sipo_deserializer #(.WIDTH(W), .REQUIRE_SOF(1'b0)) dut0 (
        .CLK(CLK), .RST(RST), .SIN(SIN), .SIN_EN(SIN_EN), .SOF(SOF),
        .DOUT(dout0), .DOUT_VALID(valid0), .DOUT_READY(DOUT_READY),
        .FRAME_ERR(ferr0), .OVERRUN(ovr0), .CLR_OVR(CLR_OVR), .BUSY(busy0));

    sipo_deserializer #(.WIDTH(W), .REQUIRE_SOF(1'b1)) dut1 (
        .CLK(CLK), .RST(RST), .SIN(SIN), .SIN_EN(SIN_EN), .SOF(SOF),
        .DOUT(dout1), .DOUT_VALID(valid1), .DOUT_READY(DOUT_READY),
        .FRAME_ERR(ferr1), .OVERRUN(ovr1), .CLR_OVR(CLR_OVR), .BUSY(busy1));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: count bits and accumulate the word arithmetically
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int c = 0; c < 2; c++) begin
                act[c] = 0; nb[c] = 0; acc[c] = 0;
                md[c] = '0; mv[c] = 0; mf[c] = 0; mo[c] = 0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                automatic bit done = 0;
                automatic bit fe = 0;
                automatic bit accept = mv[c] && DOUT_READY;
                automatic longint w = 0;
                if (SIN_EN) begin
                    if (SOF) begin
                        fe = act[c] && (nb[c] > 0);
                        act[c] = 1; nb[c] = 1; acc[c] = longint'(SIN);
                    end else if (act[c]) begin
                        acc[c] = acc[c] * 2 + longint'(SIN);
                        nb[c]++;
                        if (nb[c] == W) begin
                            done = 1; w = acc[c] % (longint'(1) << W);
                            nb[c] = 0; acc[c] = 0; act[c] = (c == 0);
                        end
                    end
                end
                mf[c] = fe;
                if (done && (!mv[c] || DOUT_READY)) begin
                    md[c] = W'(w); mv[c] = 1;
                    if (CLR_OVR) mo[c] = 0;
                end else if (done) begin
                    mo[c] = 1;
                end else begin
                    if (accept) mv[c] = 0;
                    if (CLR_OVR) mo[c] = 0;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            chk("c0_dout", 32'(dout0), 32'(md[0]));
            chk("c0_valid", 32'(valid0), 32'(mv[0]));
            chk("c0_ferr", 32'(ferr0), 32'(mf[0]));
            chk("c0_ovr", 32'(ovr0), 32'(mo[0]));
            chk("c0_busy", 32'(busy0), 32'(act[0] && nb[0] > 0));
            chk("c1_dout", 32'(dout1), 32'(md[1]));
            chk("c1_valid", 32'(valid1), 32'(mv[1]));
            chk("c1_ferr", 32'(ferr1), 32'(mf[1]));
            chk("c1_ovr", 32'(ovr1), 32'(mo[1]));
            chk("c1_busy", 32'(busy1), 32'(act[1] && nb[1] > 0));
        end
    end

    task automatic send(input logic s, input logic f);
        @(negedge CLK);
        SIN = s; SIN_EN = 1'b1; SOF = f;
    endtask

    task automatic idle(input int k = 1, input logic f = 1'b0);
        repeat (k) begin
            @(negedge CLK);
            SIN = 1'b0; SIN_EN = 1'b0; SOF = f;
        end
    endtask

    task automatic word4(input logic [3:0] v);
        logic [3:0] t;
        t = v;
        send(t[3], 1'b1);
        send(t[2], 1'b0);
        send(t[1], 1'b0);
        send(t[0], 1'b0);
    endtask

    initial begin
        RST = 1'b1; SIN = 0; SIN_EN = 0; SOF = 0; DOUT_READY = 1'b1; CLR_OVR = 0;
        #12;
        chk("rst_dout", 32'(dout1), 32'h0);
        chk("rst_valid", 32'(valid1), 32'h0);
        chk("rst_busy", 32'(busy0), 32'h0);
        @(negedge CLK); RST = 1'b0;
        idle(2);

        // 1: single framed word
        word4(4'b1011);
        idle();
        chk("t1_dout", 32'(dout1), 32'hB);
        chk("t1_valid", 32'(valid1), 32'h1);
        chk("t1_model", 32'(md[1]), 32'hB);
        idle();
        chk("t1_valid_drop", 32'(valid1), 32'h0);
        idle(2);

        // 2: 8 bits after one SOF
        word4(4'hC);
        idle(0);
        send(0, 0); chk("t2_c0_first", 32'(dout0), 32'hC); chk("t2_c1_first", 32'(dout1), 32'hC);
        send(1, 0); send(1, 0); send(0, 0);
        idle();
        chk("t2_c0_second", 32'(dout0), 32'h6);
        chk("t2_c0_valid", 32'(valid0), 32'h1);
        chk("t2_c1_ignored", 32'(valid1), 32'h0);
        chk("t2_c1_hold", 32'(dout1), 32'hC);
        idle(2);

        // 3: SOF inside a partial word
        send(1, 1); send(1, 0);
        send(0, 1); send(1, 0);
        chk("t3_ferr0", 32'(ferr0), 32'h1);
        chk("t3_ferr1", 32'(ferr1), 32'h1);
        send(0, 0);
        chk("t3_ferr_pulse", 32'(ferr1), 32'h0);
        send(1, 0);
        idle();
        chk("t3_dout", 32'(dout1), 32'h5);
        idle(2);

        // 4: overrun, drain, clear, clear coincident with a new overrun
        DOUT_READY = 1'b0;
        word4(4'hA);
        word4(4'h3);
        idle();
        chk("t4_hold", 32'(dout1), 32'hA);
        chk("t4_ovr", 32'(ovr1), 32'h1);
        DOUT_READY = 1'b1;
        idle();
        DOUT_READY = 1'b0;
        chk("t4_drained", 32'(valid1), 32'h0);
        chk("t4_dout_kept", 32'(dout1), 32'hA);
        CLR_OVR = 1'b1;
        idle();
        CLR_OVR = 1'b0;
        chk("t4_clr", 32'(ovr1), 32'h0);
        word4(4'h5);
        send(0, 1); send(1, 0); send(1, 0); send(0, 0);
        CLR_OVR = 1'b1;
        idle();
        CLR_OVR = 1'b0;
        chk("t4_ovr_sticky", 32'(ovr1), 32'h1);
        chk("t4_hold5", 32'(dout1), 32'h5);
        DOUT_READY = 1'b1;
        idle(3);

        // 5: gaps with SOF held high while SIN_EN is low
        send(1, 1); idle(1, 1);
        send(0, 0); idle(2, 1);
        send(0, 0); idle(3, 1);
        send(1, 0);
        idle();
        chk("t5_dout", 32'(dout1), 32'h9);
        chk("t5_dout0", 32'(dout0), 32'h9);
        idle(2);

        // 6: asynchronous reset mid-word
        CLR_OVR = 1'b0;
        DOUT_READY = 1'b0;
        word4(4'h7);
        send(1, 1); send(1, 0); send(1, 0);
        idle();
        chk("t6_busy_pre", 32'(busy1), 32'h1);
        #2 RST = 1'b1;
        #1;
        chk("t6_dout", 32'(dout1), 32'h0);
        chk("t6_valid", 32'(valid1), 32'h0);
        chk("t6_busy", 32'(busy1), 32'h0);
        chk("t6_ovr", 32'(ovr0), 32'h0);
        chk("t6_ferr", 32'(ferr0), 32'h0);
        @(negedge CLK); RST = 1'b0;
        DOUT_READY = 1'b1;
        send(1, 0); send(1, 0);
        idle();
        chk("t6_ignored", 32'(busy1), 32'h0);
        word4(4'hE);
        idle();
        chk("t6_new", 32'(dout1), 32'hE);
        chk("t6_new0", 32'(dout0), 32'hE);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Serial-in/parallel-out receiver that sits directly downstream of the 4-bit MSB-first parallel-to-serial shifter.
- Collects WIDTH serial bits, MSB first, under a bit-enable and start-of-frame marker.
- Presents each completed word in an output holding register with a valid/ready handshake.
- Flags framing errors and overruns so the consumer can detect lost or misaligned data.

Parameters:
- WIDTH, 4: bits per word; legal range 2 to 32.
- REQUIRE_SOF, 1: 1 = every word must start with SOF; 0 = after the first SOF, words follow back-to-back without SOF.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- SIN  input  1  serial data bit.
- SIN_EN  input  1  SIN is sampled this cycle when high.
- SOF  input  1  qualified by SIN_EN; this bit is the MSB of a new word.
- DOUT  output  WIDTH  assembled word, MSB = first bit received.
- DOUT_VALID  output  1  DOUT holds an unconsumed word.
- DOUT_READY  input  1  consumer accepts DOUT when DOUT_VALID && DOUT_READY.
- FRAME_ERR  output  1  one-cycle pulse: partial word discarded because of SOF.
- OVERRUN  output  1  sticky: a completed word was dropped.
- CLR_OVR  input  1  clears OVERRUN.
- BUSY  output  1  a partial word is in progress (state SHIFT, count > 0).

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - state = IDLE, shift register = 0, bit count = 0.
  - DOUT = 0, DOUT_VALID = 0, FRAME_ERR = 0, OVERRUN = 0, BUSY = 0.
  - Any partial word is lost.
- States:
  - IDLE: no frame in progress.
  - SHIFT: accumulating a word; count 0..WIDTH-1.
- IDLE transitions:
  - SIN_EN && SOF: shift register = SIN, count = 1, go to SHIFT.
  - SIN_EN && !SOF: bit ignored.
  - SOF && !SIN_EN: ignored in every state.
- SHIFT, SIN_EN && !SOF: shift left, new bit into LSB ({sreg[WIDTH-2:0], SIN}); count += 1.
- SHIFT, SIN_EN && SOF with count 1..WIDTH-1:
  - Partial word discarded.
  - FRAME_ERR pulses high for the next cycle.
  - The SOF bit becomes bit 1 of the new word; count = 1.
- SHIFT, SIN_EN && SOF with count 0 (REQUIRE_SOF=0, word boundary): normal start, no FRAME_ERR.
- Word completion, on the edge where the WIDTH-th bit is sampled:
  - Word = {sreg[WIDTH-2:0], SIN}; count returns to 0.
  - Next state: IDLE if REQUIRE_SOF=1, SHIFT otherwise.
  - If holding register empty, or being drained this same cycle (DOUT_VALID && DOUT_READY): DOUT = word, DOUT_VALID = 1 from the following cycle. Latency is 1 cycle after the last bit.
  - Otherwise: word dropped, DOUT unchanged, OVERRUN = 1.
- Handshake:
  - DOUT_VALID && DOUT_READY with no new word: DOUT_VALID = 0 next cycle; DOUT keeps its last value.
  - DOUT is stable while DOUT_VALID && !DOUT_READY.
  - DOUT_READY is ignored while DOUT_VALID = 0.
- OVERRUN:
  - Cleared by CLR_OVR.
  - If CLR_OVR coincides with a new overrun, OVERRUN stays 1.
- Timing with the upstream shifter: drive SOF with the cycle in which the shifter first presents the MSB, i.e. the cycle after its load. Back-to-back 4-bit words then reassemble exactly.
- Bit gaps (SIN_EN low) hold all state and are unbounded; there is no timeout.

Test Plan (WIDTH=4 unless stated):
1. RST, DOUT_READY=1; bits 1,0,1,1 with SIN_EN=1, SOF on first bit -> DOUT=4'b1011, DOUT_VALID high exactly one cycle, one cycle after the 4th bit; FRAME_ERR=0, OVERRUN=0.
2. REQUIRE_SOF=0; SOF then 8 consecutive bits 1100_0110, DOUT_READY=1 -> DOUT=4'hC then 4'h6, VALID pulses 4 cycles apart; REQUIRE_SOF=1 with the same stimulus -> only 4'hC, second 4 bits ignored.
3. SOF+bits 1,1, then SOF with bits 0,1,0,1 -> FRAME_ERR one-cycle pulse after the second SOF, DOUT=4'h5, no word 4'b11xx produced.
4. DOUT_READY=0; two complete words 4'hA then 4'h3 -> DOUT holds 4'hA, OVERRUN=1; raise DOUT_READY -> 4'hA accepted once; CLR_OVR -> OVERRUN=0; CLR_OVR coincident with another overrun -> OVERRUN stays 1.
5. Bits 1,0,0,1 with 1-3 idle cycles (SIN_EN=0) between bits, SOF held high during gaps -> DOUT=4'h9, no FRAME_ERR.
6. RST asserted mid-cycle after 3 bits -> all outputs 0 immediately, BUSY=0; following bits without SOF ignored; a new SOF word 4'hE is received correctly.
